// File: rtl/bcd_divider_pkg.sv
// Shared types and constants for the sequential BCD divider.
// Contents: FSM state enum, BCD digit and binary dividend widths, iteration count.
package bcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_CONV,
    S_DONE
  } state_e;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_DIGIT_MAX  = 9;
  localparam int BIN_DIVIDEND_W = 7;
  localparam int DIV_ITERS      = 7;

endpackage

// File: rtl/bcd_divider_bin7_to_bcd.sv
// Combinational 7-bit binary (0-99) to two BCD digits.
// Ports: bin_i 7-bit binary in; bcd_o [7:4] tens, [3:0] units.
module bin7_to_bcd
  import bcd_pkg::*;
(
  input  logic [BIN_DIVIDEND_W-1:0] bin_i,
  output logic [2*BCD_DIGIT_W-1:0]  bcd_o
);

  logic [BCD_DIGIT_W-1:0] tens;
  logic [BCD_DIGIT_W-1:0] units;

  // Tens digit is the largest i with 10*i <= bin_i.
  always_comb begin
    tens = '0;
    for (int i = 1; i <= 9; i++) begin
      if (bin_i >= 7'(i * 10)) tens = 4'(i);
    end
    units = 4'(bin_i - 7'(10 * int'(tens)));
    bcd_o = {tens, units};
  end

endmodule

// File: rtl/bcd_divider.sv
// BCD divider: 2-digit BCD dividend / 1-digit BCD divisor, start/busy/done.
// Ports: clk, rst_n (async low), start, BCDDividend[7:0], BCDDivisor[3:0] in;
// busy, done, BCDQuot[7:0], BCDRem[3:0], validation[2:0], divByZero out.
// Optional: BCD_DIVIDER_EARLY_EXIT_EN finishes from LOAD when dividend < divisor.
module bcd_divider
  import bcd_pkg::*;
#(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2*BCD_DIGIT_W-1:0] BCDDividend,
  input  logic [BCD_DIGIT_W-1:0]   BCDDivisor,
  output logic                     busy,
  output logic                     done,
  output logic [2*BCD_DIGIT_W-1:0] BCDQuot,
  output logic [BCD_DIGIT_W-1:0]   BCDRem,
  output logic [2:0]               validation,
  output logic                     divByZero
);

  localparam int DIV_CYC = DIV_ITERS / ITER_PER_CYCLE;

  state_e state_q, state_d;
  logic [7:0]                opa_q, opa_d;
  logic [3:0]                opb_q, opb_d;
  logic [BIN_DIVIDEND_W-1:0] work_q, work_d;
  logic [3:0]                rem_q, rem_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [7:0]                quot_q, quot_d;
  logic [3:0]                remo_q, remo_d;
  logic [2:0]                vld_q, vld_d;
  logic                      dbz_q, dbz_d;

  logic [2:0]                vld;
  logic [BIN_DIVIDEND_W-1:0] bin_dvd;
  logic [4:0]                trial;
  logic [7:0]                conv_bcd;

  bin7_to_bcd u_conv (
    .bin_i (work_q),
    .bcd_o (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      work_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      vld_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      vld_q   <= vld_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    work_d  = work_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    vld_d   = vld_q;
    dbz_d   = dbz_q;
    trial   = '0;

    vld = {opb_q > 4'(BCD_DIGIT_MAX),
           opa_q[3:0] > 4'(BCD_DIGIT_MAX),
           opa_q[7:4] > 4'(BCD_DIGIT_MAX)};
    // tens*10 = tens*8 + tens*2
    bin_dvd = {opa_q[7:4], 3'b000}
            + {2'b00, opa_q[7:4], 1'b0}
            + {3'b000, opa_q[3:0]};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = BCDDividend;
          opb_d   = BCDDivisor;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        work_d = bin_dvd;
        rem_d  = '0;
        cnt_d  = 3'(DIV_CYC - 1);
        if (|vld || opb_q == '0) begin
          quot_d  = '0;
          remo_d  = '0;
          vld_d   = vld;
          dbz_d   = ~|vld;
          state_d = S_DONE;
        end
`ifdef BCD_DIVIDER_EARLY_EXIT_EN
        else if (bin_dvd < 7'(opb_q)) begin
          quot_d  = '0;
          remo_d  = opa_q[3:0];
          vld_d   = '0;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
`endif
        else begin
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        // Dividend bits shift out at the top while quotient bits
        // shift in at the bottom; after 7 steps work holds the quotient.
        for (int i = 0; i < ITER_PER_CYCLE; i++) begin
          trial  = {rem_d, work_d[6]};
          if (trial >= {1'b0, opb_q}) begin
            rem_d  = 4'(trial - {1'b0, opb_q});
            work_d = {work_d[5:0], 1'b1};
          end else begin
            rem_d  = trial[3:0];
            work_d = {work_d[5:0], 1'b0};
          end
        end
        if (cnt_q == '0) state_d = S_CONV;
        else cnt_d = cnt_q - 3'd1;
      end
      S_CONV: begin
        quot_d  = conv_bcd;
        remo_d  = rem_q;
        vld_d   = '0;
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign BCDQuot    = quot_q;
  assign BCDRem     = remo_q;
  assign validation = vld_q;
  assign divByZero  = dbz_q;

endmodule

// File: tb/tb_bcd_divider.sv
// Self-checking bench for bcd_divider: directed cases, full sweep,
// busy-time start rejection, mid-operation reset, optional early exit.
module tb_bcd_divider;

  localparam int ITER = 1;
  localparam int LAT_FULL = 3 + 7 / ITER;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] BCDDividend;
  logic [3:0] BCDDivisor;
  logic       busy;
  logic       done;
  logic [7:0] BCDQuot;
  logic [3:0] BCDRem;
  logic [2:0] validation;
  logic       divByZero;

  bcd_divider #(.ITER_PER_CYCLE(ITER)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .BCDDividend (BCDDividend),
    .BCDDivisor  (BCDDivisor),
    .busy        (busy),
    .done        (done),
    .BCDQuot     (BCDQuot),
    .BCDRem      (BCDRem),
    .validation  (validation),
    .divByZero   (divByZero)
  );

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic [2:0] v;
    logic       dbz;
    int         lat;
    int         c0;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;
  int   done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    int t, u, bin, q;
    t   = int'(a[7:4]);
    u   = int'(a[3:0]);
    bin = t * 10 + u;
    e.v = {b > 4'd9, u > 9, t > 9};
    e.c0 = 0;
    if (e.v != 3'b000 || b == 4'd0) begin
      e.q = 8'h00;
      e.r = 4'h0;
      e.dbz = (e.v == 3'b000);
      e.lat = 2;
    end else begin
      q = bin / int'(b);
      e.q = {4'(q / 10), 4'(q % 10)};
      e.r = 4'(bin % int'(b));
      e.dbz = 1'b0;
      e.lat = LAT_FULL;
`ifdef BCD_DIVIDER_EARLY_EXIT_EN
      if (bin < int'(b)) e.lat = 2;
`endif
    end
    return e;
  endfunction

  // Drives a start pulse that the DUT samples on the next edge.
  task automatic start_op(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    BCDDividend = a;
    BCDDivisor  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(a, b);
    e.c0 = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (done !== 1'b1) begin
      chk({tag, "_timeout"}, 32'(done), 32'd1);
      return;
    end
    chk({tag, "_lat"}, 32'(cyc - e.c0 + 1), 32'(e.lat));
    chk({tag, "_quot"}, 32'(BCDQuot), 32'(e.q));
    chk({tag, "_rem"}, 32'(BCDRem), 32'(e.r));
    chk({tag, "_vld"}, 32'(validation), 32'(e.v));
    chk({tag, "_dbz"}, 32'(divByZero), 32'(e.dbz));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0;
    start = 1'b0;
    BCDDividend = 8'h00;
    BCDDivisor  = 4'h0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_outs", 32'({BCDQuot, BCDRem, validation, divByZero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic 95 / 7
    start_op(8'h95, 4'h7);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done("d95_7");
    chk("d95_7_q_const", 32'(BCDQuot), 32'h13);
    chk("d95_7_r_const", 32'(BCDRem), 32'h4);
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_quot", 32'(BCDQuot), 32'h13);
    chk("hold_rem", 32'(BCDRem), 32'h4);

    // Divide by zero and invalid digits
    start_op(8'h42, 4'h0);
    wait_done("dbz");
    @(posedge clk);
    #1;
    start_op(8'h1A, 4'hC);
    wait_done("inv_1A_C");
    chk("inv_vld_const", 32'(validation), 32'b110);
    @(posedge clk);
    #1;
    start_op(8'hA5, 4'h0);
    wait_done("inv_A5_0");
    @(posedge clk);
    #1;

    // start during busy and during DONE is ignored
    start_op(8'h95, 4'h7);
    repeat (2) @(posedge clk);
    #1;
    BCDDividend = 8'h99;
    BCDDivisor  = 4'h1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("repulse");
    BCDDividend = 8'h99;
    BCDDivisor  = 4'h1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("done_cycle_start_ign", 32'(busy), 32'd0);
    start_op(8'h99, 4'h1);
    wait_done("fresh_99_1");
    @(posedge clk);
    #1;

    // Reset in DIV cycle 3
    start_op(8'h95, 4'h7);
    repeat (3) @(posedge clk);
    #2;
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_outs", 32'({BCDQuot, BCDRem, validation, divByZero}), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt - dc), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

`ifdef BCD_DIVIDER_EARLY_EXIT_EN
    start_op(8'h05, 4'h9);
    wait_done("early_05_9");
    chk("early_rem_const", 32'(BCDRem), 32'h5);
    @(posedge clk);
    #1;
`endif

    // Full sweep of valid operands
    for (int d = 0; d < 100; d++) begin
      for (int b = 1; b <= 9; b++) begin
        start_op({4'(d / 10), 4'(d % 10)}, 4'(b));
        wait_done($sformatf("sw_%0d_%0d", d, b));
        @(posedge clk);
        #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
